// File: rtl/vlc_pkg.sv
// ---------------------------------------------------------------------------
// vlc_pkg
// Shared constants, packer state encoding and helpers for the VLC bit packer.
//   WORD_WIDTH   : packed output word width (32 only)
//   MAX_CODE_LEN : longest code the VLC stage may present in one cycle
//   pack_state_t : ACCUM (normal packing) / TAIL (emit held flush remainder)
//   ceil_bytes   : bytes needed to carry 0..32 bits
// ---------------------------------------------------------------------------
package vlc_pkg;

   localparam int WORD_WIDTH   = 32;
   localparam int MAX_CODE_LEN = 32;

   typedef enum logic {
      ACCUM = 1'b0,
      TAIL  = 1'b1
   } pack_state_t;

   // Number of bytes touched by nbits (0..32) bits, rounded up.
   function automatic logic [2:0] ceil_bytes(input logic [5:0] nbits);
      logic [6:0] t;
      t = {1'b0, nbits} + 7'd7;
      return t[5:3];
   endfunction

endpackage

// File: rtl/vlc_code_mask.sv
// ---------------------------------------------------------------------------
// vlc_code_mask
// Combinational front end of the packer: clamps the code length to
// MAX_CODE_LEN, strips value bits at and above the length, and flags an
// over-long length request.
//   val         in  32  code value, right-aligned
//   size_of_bit in  32  requested code length
//   len         out 6   clamped length 0..32
//   code        out 32  val with bits >= len cleared
//   len_over    out 1   size_of_bit exceeded MAX_CODE_LEN
// ---------------------------------------------------------------------------
module vlc_code_mask
   import vlc_pkg::*;
(
   input  logic [31:0] val,
   input  logic [31:0] size_of_bit,
   output logic [5:0]  len,
   output logic [31:0] code,
   output logic        len_over
);

   logic [32:0] mask;

   always_comb begin
      len_over = (size_of_bit > 32'(MAX_CODE_LEN));
      len      = len_over ? 6'(MAX_CODE_LEN) : size_of_bit[5:0];
      // 33-bit mask so that len = 32 yields all ones without overflow.
      mask     = (33'd1 << len) - 33'd1;
      code     = val & mask[31:0];
   end

endmodule

// File: rtl/vlc_bit_packer.sv
// ---------------------------------------------------------------------------
// vlc_bit_packer
// Packs variable-length codes MSB-first into 32-bit big-endian words. On a
// flush the segment is byte-aligned, the final partial word is emitted with
// out_last and the segment bit count is reported on total_bits. One code is
// accepted every cycle; there is no backpressure.
//   clock        in  1          rising-edge clock
//   reset        in  1          synchronous active-high reset
//   enable       in  1          code valid this cycle
//   val          in  32         code value, right-aligned
//   size_of_bit  in  32         code length (0..32 legal)
//   flush_bit    in  1          end of slice, qualified by enable
//   out_valid    out 1          out_data valid
//   out_data     out 32         packed word, first bit in bit 31
//   out_bytes    out 3          valid bytes in out_data (1..4)
//   out_last     out 1          final word of the flushed segment
//   total_bits   out CNT_WIDTH  bits accepted since the last flush
//   len_error    out 1          sticky: size_of_bit > 32 seen
// ---------------------------------------------------------------------------
module vlc_bit_packer
   import vlc_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [31:0]           val,
   input  logic [31:0]           size_of_bit,
   input  logic                  flush_bit,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic [2:0]            out_bytes,
   output logic                  out_last,
   output logic [CNT_WIDTH-1:0]  total_bits,
   output logic                  len_error
);

   localparam int ACC_W = 2 * WORD_WIDTH;

   // Saturating add of a code length to the segment bit counter.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [5:0]           b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {{(CNT_WIDTH-5){1'b0}}, b};
      return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   // Registered state. The accumulator is left-aligned: bit ACC_W-1 is the
   // oldest unsent bit. fill normally stays below 32 after an emission, but
   // a full 32-bit code accepted during TAIL can leave exactly 32 bits held;
   // the 64-bit accumulator still has room for one more 32-bit code, and
   // the next accepted code drains that word.
   pack_state_t          state_p1;
   logic [ACC_W-1:0]     acc_p1;
   logic [5:0]           fill_p1;
   logic [CNT_WIDTH-1:0] cnt_p1;

   // Stage 0: mask, position and merge the incoming code (combinational)
   logic [5:0]           len_p0;
   logic [31:0]          code_p0;
   logic                 len_over_p0;
   logic [6:0]           f_p0;
   logic [6:0]           shift_p0;
   logic [6:0]           tail_shift_p0;
   logic [ACC_W-1:0]     placed_p0;
   logic [ACC_W-1:0]     placed_tail_p0;
   logic [ACC_W-1:0]     merged_p0;
   logic [CNT_WIDTH-1:0] sum_cnt_p0;

   vlc_code_mask u_code_mask (
      .val         (val),
      .size_of_bit (size_of_bit),
      .len         (len_p0),
      .code        (code_p0),
      .len_over    (len_over_p0)
   );

   assign f_p0           = {1'b0, fill_p1} + {1'b0, len_p0};
   assign shift_p0       = 7'd64 - f_p0;
   assign tail_shift_p0  = 7'd64 - {1'b0, len_p0};
   assign placed_p0      = {{(ACC_W-32){1'b0}}, code_p0} << shift_p0;
   assign placed_tail_p0 = {{(ACC_W-32){1'b0}}, code_p0} << tail_shift_p0;
   assign merged_p0      = acc_p1 | placed_p0;
   assign sum_cnt_p0     = sat_add(cnt_p1, len_p0);

   // Next-state and emission decode
   pack_state_t          state_n;
   logic [ACC_W-1:0]     acc_n;
   logic [5:0]           fill_n;
   logic [CNT_WIDTH-1:0] cnt_n;
   logic                 ov_n;
   logic [WORD_WIDTH-1:0] od_n;
   logic [2:0]           ob_n;
   logic                 ol_n;
   logic [CNT_WIDTH-1:0] tb_n;

   always_comb begin
      state_n = state_p1;
      acc_n   = acc_p1;
      fill_n  = fill_p1;
      cnt_n   = cnt_p1;
      ov_n    = 1'b0;
      od_n    = '0;
      ob_n    = 3'd0;
      ol_n    = 1'b0;
      tb_n    = cnt_p1;

      case (state_p1)
         ACCUM: begin
            if (enable) begin
               cnt_n = sum_cnt_p0;
               tb_n  = sum_cnt_p0;
               if (flush_bit) begin
                  if (f_p0 == 7'd0) begin
                     cnt_n  = '0;
                     acc_n  = '0;
                     fill_n = 6'd0;
                  end else if (f_p0 <= 7'd32) begin
                     ov_n   = 1'b1;
                     od_n   = merged_p0[ACC_W-1 -: WORD_WIDTH];
                     ob_n   = ceil_bytes(6'(f_p0));
                     ol_n   = 1'b1;
                     cnt_n  = '0;
                     acc_n  = '0;
                     fill_n = 6'd0;
                  end else begin
                     // Full word now, remainder goes out from TAIL. The
                     // final count is held in cnt for the TAIL emission.
                     ov_n    = 1'b1;
                     od_n    = merged_p0[ACC_W-1 -: WORD_WIDTH];
                     ob_n    = 3'd4;
                     acc_n   = {merged_p0[WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
                     fill_n  = 6'(f_p0 - 7'd32);
                     state_n = TAIL;
                  end
               end else if (f_p0 >= 7'd32) begin
                  ov_n   = 1'b1;
                  od_n   = merged_p0[ACC_W-1 -: WORD_WIDTH];
                  ob_n   = 3'd4;
                  acc_n  = {merged_p0[WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
                  fill_n = 6'(f_p0 - 7'd32);
               end else begin
                  acc_n  = merged_p0;
                  fill_n = 6'(f_p0);
               end
            end
         end

         TAIL: begin
            ov_n = 1'b1;
            od_n = acc_p1[ACC_W-1 -: WORD_WIDTH];
            ob_n = ceil_bytes(fill_p1);
            ol_n = 1'b1;
            tb_n = cnt_p1;
            // The input arriving now starts a fresh segment in an empty
            // accumulator. A non-empty flush here is itself a complete
            // segment of at most 32 bits, so it is emitted by another TAIL.
            if (enable) begin
               acc_n   = placed_tail_p0;
               fill_n  = len_p0;
               cnt_n   = {{(CNT_WIDTH-6){1'b0}}, len_p0};
               state_n = (flush_bit && (len_p0 != 6'd0)) ? TAIL : ACCUM;
            end else begin
               acc_n   = '0;
               fill_n  = 6'd0;
               cnt_n   = '0;
               state_n = ACCUM;
            end
         end
      endcase
   end

   // Stage 1: registered state and outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_p1   <= ACCUM;
         acc_p1     <= '0;
         fill_p1    <= 6'd0;
         cnt_p1     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_bytes  <= 3'd0;
         out_last   <= 1'b0;
         total_bits <= '0;
         len_error  <= 1'b0;
      end else begin
         state_p1   <= state_n;
         acc_p1     <= acc_n;
         fill_p1    <= fill_n;
         cnt_p1     <= cnt_n;
         out_valid  <= ov_n;
         out_data   <= od_n;
         out_bytes  <= ob_n;
         out_last   <= ol_n;
         total_bits <= tb_n;
         len_error  <= len_error | (enable & len_over_p0);
      end
   end

endmodule
